// File: rtl/axis_downsizer.sv
// AXI4-Stream width down-converter: splits each wide input beat into RATIO narrow
// output beats, least-significant slice first, optionally trimming empty trailing slices.
module axis_downsizer #(
  parameter int S_DATA_WIDTH = 128,
  parameter int M_DATA_WIDTH = 32,
  parameter int KEEP_ENABLE  = 0,
  parameter int S_KEEP_WIDTH = S_DATA_WIDTH / 8,
  parameter int M_KEEP_WIDTH = M_DATA_WIDTH / 8,
  parameter int LAST_ENABLE  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [M_KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast
);

  localparam int RATIO = S_DATA_WIDTH / M_DATA_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  logic [S_DATA_WIDTH-1:0] data_reg;
  logic [S_KEEP_WIDTH-1:0] keep_reg;
  logic                    last_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [IDX_W-1:0]        fin_reg;
  logic                    full_reg;

  logic [S_KEEP_WIDTH-1:0] keep_in;
  logic                    last_in;
  logic [IDX_W-1:0]        fin_next;
  logic [RATIO-1:0]        chunk_nz;
  logic                    accept_in;
  logic                    out_fire;
  logic                    at_final;

  logic [M_DATA_WIDTH-1:0] data_slice [RATIO];
  logic [M_KEEP_WIDTH-1:0] keep_slice [RATIO];

  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_slice
      assign data_slice[gi] = data_reg[gi*M_DATA_WIDTH +: M_DATA_WIDTH];
      assign keep_slice[gi] = keep_reg[gi*M_KEEP_WIDTH +: M_KEEP_WIDTH];
      assign chunk_nz[gi]   = |s_axis_tkeep[gi*M_KEEP_WIDTH +: M_KEEP_WIDTH];
    end
  endgenerate

  // Without keep handling the held keep is forced to all-ones so every slice reports full bytes.
  assign keep_in = (KEEP_ENABLE != 0) ? s_axis_tkeep : {S_KEEP_WIDTH{1'b1}};
  assign last_in = (LAST_ENABLE != 0) && s_axis_tlast;

  // Trimmed last beat ends at the highest slice carrying any valid byte (slice 0 if none).
  always_comb begin
    fin_next = LAST_IDX;
    if ((KEEP_ENABLE != 0) && last_in) begin
      fin_next = '0;
      for (int i = 1; i < RATIO; i++) begin
        if (chunk_nz[i]) fin_next = IDX_W'(i);
      end
    end
  end

  assign at_final      = (idx_reg == fin_reg);
  assign s_axis_tready = rst && (!full_reg || (m_axis_tready && at_final));
  assign accept_in     = s_axis_tvalid && s_axis_tready;
  assign out_fire      = full_reg && m_axis_tready;

  assign m_axis_tdata  = data_slice[idx_reg];
  assign m_axis_tkeep  = keep_slice[idx_reg];
  assign m_axis_tvalid = full_reg;
  assign m_axis_tlast  = last_reg && at_final;

  // Capture takes priority over draining the final slice so back-to-back beats leave no bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_reg <= '0;
      keep_reg <= '0;
      last_reg <= 1'b0;
      idx_reg  <= '0;
      fin_reg  <= LAST_IDX;
      full_reg <= 1'b0;
    end else if (accept_in) begin
      data_reg <= s_axis_tdata;
      keep_reg <= keep_in;
      last_reg <= last_in;
      idx_reg  <= '0;
      fin_reg  <= fin_next;
      full_reg <= 1'b1;
    end else if (out_fire) begin
      if (at_final) begin
        full_reg <= 1'b0;
      end else begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

endmodule

// File: doc/axis_downsizer.md
# axis_downsizer

AXI4-Stream width down-converter placed directly downstream of `axis_fifo`. It splits each wide input beat into RATIO narrow output beats, least-significant slice first. It preserves frame boundaries and, with `KEEP_ENABLE`, trims unused trailing slices of the last beat. The block is fully registered on its output and sustains one output beat per cycle under continuous back-to-back traffic.

## Interface

**Parameters**
- `S_DATA_WIDTH`, default 128: input tdata width.
- `M_DATA_WIDTH`, default 32: output tdata width.
  - Must divide `S_DATA_WIDTH` exactly; RATIO = `S_DATA_WIDTH`/`M_DATA_WIDTH`, RATIO ≥ 2.
- `KEEP_ENABLE`, default 0: enables tkeep handling.
  - When 0, `s_axis_tkeep` is ignored and `m_axis_tkeep` is driven all-ones.
- `S_KEEP_WIDTH`, default `S_DATA_WIDTH`/8.
- `M_KEEP_WIDTH`, default `M_DATA_WIDTH`/8.
- `LAST_ENABLE`, default 1: when 0, `s_axis_tlast` is treated as 0.

**Ports**
- `clk`, in, 1: single clock; all logic on rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `s_axis_tdata`, in, `S_DATA_WIDTH`
- `s_axis_tkeep`, in, `S_KEEP_WIDTH`
- `s_axis_tvalid`, in, 1
- `s_axis_tready`, out, 1
- `s_axis_tlast`, in, 1
- `m_axis_tdata`, out, `M_DATA_WIDTH`
- `m_axis_tkeep`, out, `M_KEEP_WIDTH`
- `m_axis_tvalid`, out, 1
- `m_axis_tready`, in, 1
- `m_axis_tlast`, out, 1

## Operation

**State**
- Holding register: data, keep, last.
- Slice index `idx`, width clog2(RATIO).
- Final index `fin`, latched at capture.
- Flag `full`.

**Capture**
- An input beat is accepted when `s_axis_tvalid && s_axis_tready`.
- On acceptance: the register loads the beat, `idx` is set to 0, `full` is set to 1.

**Final index `fin`**
- Non-last beat, or `KEEP_ENABLE`=0: `fin` = RATIO-1.
- Last beat with `KEEP_ENABLE`=1: `fin` = the highest slice index whose keep chunk is non-zero.
  - If the whole tkeep is zero, `fin` = 0.

**Output drive**
- `m_axis_tdata` = slice `idx` of the held data: bits [`idx`*`M_DATA_WIDTH` +: `M_DATA_WIDTH`].
- `m_axis_tkeep` = the matching keep chunk.
- `m_axis_tvalid` = `full`.
- `m_axis_tlast` = held last && (`idx` == `fin`).

**Advance** (on `m_axis_tvalid && m_axis_tready`)
- If `idx` < `fin`: `idx` increments by 1.
- If `idx` == `fin`: `full` clears, unless a new beat is captured in the same cycle.

**Ready**
- `s_axis_tready` = !`full` || (`m_axis_tready` && `idx` == `fin`).
- It is a combinational function of registered state and `m_axis_tready`. There is no path from `s_axis_tvalid`.

**Simultaneous events**
- When the final slice drains and a new beat is captured in the same edge, capture wins: `full` stays 1 and `idx` reloads to 0.

**Reset**
- `rst` low forces, asynchronously: `full`=0, `idx`=0, `fin`=RATIO-1, held data/keep/last=0.
- Resulting outputs: `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tdata`=0, `m_axis_tkeep`=0.
- `s_axis_tready` is forced 0 while `rst` is low.
- A reset mid-frame discards the held beat and any undelivered slices. No partial slice is emitted afterwards.

**Stability**
- While `m_axis_tvalid`=1 and `m_axis_tready`=0, all `m_axis_*` outputs hold stable.

## Timing

- Latency: slice 0 appears on `m_axis` in the cycle after input acceptance. Total of 1 cycle.
- Throughput: RATIO output beats per input beat.
  - With `m_axis_tready` held high and input always valid, `m_axis_tvalid` stays high with no bubbles.
  - `s_axis_tready` pulses high once every RATIO cycles; every `fin`+1 cycles for trimmed last beats.
- `m_axis_tvalid` never deasserts without a completed handshake on the current slice.
- First acceptance is possible on the first rising edge after `rst` deasserts.

## Test plan

1. **Basic split.**
   - Stimulus: reset, then one beat with tdata = 0x44444444_33333333_22222222_11111111, tlast=1, `m_axis_tready`=1.
   - Required: outputs 0x11111111, 0x22222222, 0x33333333, 0x44444444 on consecutive cycles; `m_axis_tlast` only on the 4th beat.
2. **Streaming.**
   - Stimulus: 64 back-to-back beats, `m_axis_tready`=1.
   - Required: 256 output beats with no tvalid gaps; `s_axis_tready` high exactly on cycles where `idx`=3.
3. **Back-pressure.**
   - Stimulus: random `m_axis_tready` (50%) and random `s_axis_tvalid` over 2048 beats.
   - Required: the output stream equals the input split in order; no output changes while stalled.
4. **Keep trim** (`KEEP_ENABLE`=1).
   - Stimulus: last beat with tkeep = 0x00FF.
   - Required: exactly 2 output beats, both with tkeep 0xF, tlast on the 2nd.
   - Stimulus: tkeep = 0x0000 with tlast=1.
   - Required: 1 beat, tkeep 0x0, tlast=1.
5. **Reset mid-frame.**
   - Stimulus: assert `rst` low after slice 1 is accepted.
   - Required: `m_axis_tvalid` drops to 0 immediately (asynchronously).
   - Required after release: the next input beat starts at slice 0; no stale slices 2 or 3 appear.
6. **Drain/capture collision.**
   - Stimulus: new beat valid in the same cycle slice 3 is accepted.
   - Required: the next cycle shows the new beat's slice 0, with `m_axis_tvalid` continuously 1.
